// File: rtl/lcd_pkg.sv
// Shared LCD constants, message payload and arbiter state encoding.
package lcd_pkg;

  localparam int unsigned LCD_CHARS  = 16;
  localparam int unsigned LCD_LINE_W = 128;

  localparam logic [7:0]            ASCII_SPACE = 8'h20;
  localparam logic [LCD_LINE_W-1:0] BLANK_LINE  = {LCD_CHARS{ASCII_SPACE}};

  // Two rows of sixteen ASCII characters, byte 0 (leftmost) at the MSB end.
  typedef struct packed {
    logic [LCD_LINE_W-1:0] line1;
    logic [LCD_LINE_W-1:0] line2;
  } lcd_msg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from last+1 with wrap-around.
module lcd_rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned AID_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [AID_W-1:0] last,
  output logic             found_c,
  output logic [AID_W-1:0] grant_c
);

  logic [AID_W-1:0] idx;

  // Walk the rotated order once; the first hit wins.
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = AID_W'((32'(last) + i) % NREQ);
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        grant_c = idx;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one 16x2 LCD between NREQ message sources.
// Each granted message is held on line1/line2 for DWELL_CYCLES clocks.
// Optional: define LCD_ARB_PREEMPT_EN to let source 0 cut a dwell short.
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter  int unsigned NREQ         = 3,
  parameter  int unsigned DWELL_CYCLES = 1400000,
  parameter  int unsigned CNT_W        = 32,
  localparam int unsigned AID_W        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*LCD_LINE_W-1:0] req_line1,
  input  logic [NREQ*LCD_LINE_W-1:0] req_line2,
  output logic [LCD_LINE_W-1:0]      line1,
  output logic [LCD_LINE_W-1:0]      line2,
  output logic [AID_W-1:0]           active_id,
  output logic                       busy
);

  arb_state_e       state_q, state_d;
  logic [AID_W-1:0] g_q, g_d;
  logic [AID_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lcd_msg_t         disp_q, disp_d;
  logic [AID_W-1:0] aid_q, aid_d;
  logic [NREQ-1:0]  ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             pre_q, pre_d;

  logic             pick_found;
  logic [AID_W-1:0] pick_idx;
  lcd_msg_t         src_msg [NREQ];

  // Unpack the flat source buses into per-source messages.
  for (genvar k = 0; k < NREQ; k++) begin : g_src
    assign src_msg[k].line1 = req_line1[k*LCD_LINE_W +: LCD_LINE_W];
    assign src_msg[k].line2 = req_line2[k*LCD_LINE_W +: LCD_LINE_W];
  end

  lcd_rr_pick #(
    .NREQ  (NREQ),
    .AID_W (AID_W)
  ) u_pick (
    .req     (req_valid),
    .last    (rr_q),
    .found_c (pick_found),
    .grant_c (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    aid_d   = aid_q;
    ready_d = '0;
    pre_d   = pre_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          g_d               = pick_idx;
          ready_d[pick_idx] = 1'b1;
          pre_d             = 1'b0;
          state_d           = LOAD;
        end
      end

      LOAD: begin
        // Ready is up this cycle; a dropped valid abandons the grant.
        state_d = IDLE;
        if (req_valid[g_q]) begin
          disp_d  = src_msg[g_q];
          aid_d   = g_q;
          if (!pre_q) begin
            rr_d = g_q;
          end
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
          state_d = DWELL;
        end
      end

      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`ifdef LCD_ARB_PREEMPT_EN
        // Urgent source 0 interrupts any other source's dwell; rr is frozen.
        if (req_valid[0] && (aid_q != '0)) begin
          g_d        = '0;
          ready_d    = '0;
          ready_d[0] = 1'b1;
          pre_d      = 1'b1;
          state_d    = LOAD;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= AID_W'(NREQ - 1);
      cnt_q   <= '0;
      disp_q  <= '{line1: BLANK_LINE, line2: BLANK_LINE};
      aid_q   <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      aid_q   <= aid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
    end
  end

  assign req_ready = ready_q;
  assign line1     = disp_q.line1;
  assign line2     = disp_q.line2;
  assign active_id = aid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Bench for lcd_msg_arbiter: random sources against a timestamp-based model
// of the grant/dwell schedule, plus directed reset, abort and fairness cases.
module tb_lcd_msg_arbiter;
  import lcd_pkg::*;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned DWELL = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_line1;
  logic [NREQ*128-1:0]  req_line2;
  logic [127:0]         line1;
  logic [127:0]         line2;
  logic [1:0]           active_id;
  logic                 busy;

  logic [127:0] d1 [NREQ];
  logic [127:0] d2 [NREQ];

  int n_checks = 0;
  int n_errors = 0;

  // model: edge index, next IDLE-sampling edge, LOAD edge, last load edge
  int           e, t_idle, t_load, load_e, m_rr, m_g;
  bit           m_pre;
  logic [127:0] exp_l1, exp_l2;
  logic [1:0]   exp_aid;
  logic [2:0]   exp_ready;
  bit           exp_busy;
  logic [2:0]   rdy_prev;

  int           gr_edge [$];
  int           gr_id   [$];

  logic [127:0] pt;

  always #5 clk = ~clk;

  assign req_line1 = {d1[2], d1[1], d1[0]};
  assign req_line2 = {d2[2], d2[1], d2[0]};

  lcd_msg_arbiter #(
    .NREQ         (NREQ),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_line1 (req_line1),
    .req_line2 (req_line2),
    .line1     (line1),
    .line2     (line2),
    .active_id (active_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic int rr_search(input int last, input logic [2:0] v);
    for (int i = 1; i <= int'(NREQ); i++) begin
      int idx;
      idx = (last + i) % int'(NREQ);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    e = 0; t_idle = 0; t_load = -1; load_e = -1;
    m_rr = int'(NREQ) - 1; m_g = 0; m_pre = 0;
    exp_l1 = BLANK_LINE; exp_l2 = BLANK_LINE;
    exp_aid = '0; exp_ready = '0; exp_busy = 0;
  endtask

  // Predict outputs after edge e from the inputs present at that edge.
  task automatic model_edge();
    exp_ready = '0;
    if (e == t_load) begin
      t_load = -1;
      if (req_valid[m_g]) begin
        exp_l1  = d1[m_g];
        exp_l2  = d2[m_g];
        exp_aid = 2'(m_g);
        if (!m_pre) m_rr = m_g;
        load_e  = e;
        t_idle  = e + int'(DWELL) + 1;
      end else begin
        load_e  = -1;
        t_idle  = e + 1;
      end
    end else if (e == t_idle) begin
      if (req_valid != '0) begin
        m_g = rr_search(m_rr, req_valid);
        exp_ready[m_g] = 1'b1;
        t_load = e + 1;
        t_idle = -1;
        m_pre  = 0;
      end else begin
        t_idle = e + 1;
      end
    end
`ifdef LCD_ARB_PREEMPT_EN
    else if (t_idle > e && req_valid[0] && exp_aid != 2'd0) begin
      m_g = 0;
      exp_ready[0] = 1'b1;
      t_load = e + 1;
      t_idle = -1;
      load_e = -1;
      m_pre  = 1;
    end
`endif
    exp_busy = (t_idle != e + 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ready", 128'(req_ready), 128'(exp_ready));
    check("line1", line1, exp_l1);
    check("line2", line2, exp_l2);
    check("active_id", 128'(active_id), 128'(exp_aid));
    check("busy", 128'(busy), 128'(exp_busy));
    if (req_ready != '0) begin
      gr_edge.push_back(e);
      for (int k = 0; k < int'(NREQ); k++) if (req_ready[k]) gr_id.push_back(k);
    end
    e++;
  endtask

  // Sources hold valid+data until accepted; occasionally drop (abort cases).
  task automatic stim_update();
    logic [2:0] rdy_now;
    rdy_now = req_ready;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (req_valid[k] && rdy_prev[k]) begin
        if ($urandom_range(1, 0) == 1) begin
          d1[k] = rnd128(); d2[k] = rnd128();
        end else begin
          req_valid[k] = 1'b0;
        end
      end else if (req_valid[k]) begin
        if (rdy_now[k] && $urandom_range(7, 0) == 0) req_valid[k] = 1'b0;
        else if ($urandom_range(31, 0) == 0)         req_valid[k] = 1'b0;
      end else if ($urandom_range(3, 0) == 0) begin
        d1[k] = rnd128(); d2[k] = rnd128();
        req_valid[k] = 1'b1;
      end
    end
    rdy_prev = rdy_now;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_line1"}, line1, BLANK_LINE);
    check({tag, "_line2"}, line2, BLANK_LINE);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_ready"}, 128'(req_ready), 128'(0));
    check({tag, "_aid"}, 128'(active_id), 128'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rdy_prev = '0;
  endtask

  initial begin
    bit found;
    pt = "PLAINTEXT       ";
    req_valid = '0;
    rdy_prev  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      d1[k] = rnd128(); d2[k] = rnd128();
    end
    model_reset();

    // Reset state, then 50 idle cycles.
    #12;
    check_reset_outputs("por");
    release_reset();
    repeat (50) step();

    // Single source 0 with a known message.
    d1[0] = pt;
    req_valid = 3'b001;
    repeat (14) step();
    check("plaintext_shown", line1, pt);

    // Source 1 drops valid during its LOAD cycle; source 2 should follow.
    req_valid = '0;
    for (int n = 0; n < 40 && t_idle != e; n++) step();
    check("reach_idle", 128'(t_idle == e), 128'(1));
    req_valid = 3'b110;
    step();
    req_valid = 3'b100;
    step();
    check("abort_hold", line1, pt);
    repeat (15) step();

    // Fairness from reset with everyone continuously valid.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_fair");
    req_valid = 3'b111;
    gr_edge.delete();
    gr_id.delete();
    release_reset();
    repeat (40) step();
`ifndef LCD_ARB_PREEMPT_EN
    check("grant_count", 128'(gr_id.size() >= 4), 128'(1));
    if (gr_id.size() >= 4) begin
      check("order0", 128'(gr_id[0]), 128'(0));
      check("order1", 128'(gr_id[1]), 128'(1));
      check("order2", 128'(gr_id[2]), 128'(2));
      check("order3", 128'(gr_id[3]), 128'(0));
      for (int i = 1; i < 4; i++)
        check("spacing", 128'(gr_edge[i] - gr_edge[i-1]), 128'(DWELL + 2));
    end
`endif

    // Random traffic until source 2 is four cycles into its dwell, then reset.
    rdy_prev = '0;
    found = 0;
    for (int n = 0; n < 3000 && !found; n++) begin
      step();
      stim_update();
      if (load_e >= 0 && exp_aid == 2'd2 && t_idle > e - 1 && (e - 1 - load_e) == 4)
        found = 1;
    end
    check("dwell2_reached", 128'(found), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    req_valid = 3'b101;
    repeat (2) @(negedge clk);
    release_reset();
    step();
    check("first_after_rst", 128'(req_ready), 128'(3'b001));

    // Long random run.
    for (int n = 0; n < 3000; n++) begin
      stim_update();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
